// File: rtl/branch_update_ctrl_if.sv
// branch_update_ctrl_if
// Bundles the fetch-side queue push, the execute-side resolution, the BTB
// training outputs and the fetch redirect/flush outputs of branch_update_ctrl.
//
// Optional feature macro: BRU_STATS_EN (adds stat_resolved / stat_mispred).
//
// Modports:
//   master - fetch/execute/BTB side: drives fq_*, ex_*; observes everything else
//   slave  - branch_update_ctrl itself
//
// Signals:
//   fq_push, fq_pc, fq_pred_outcome, fq_hit, fq_pred_target  prediction record
//   fq_full, fq_empty                                        queue status
//   ex_valid, ex_taken, ex_target                            oldest branch resolved
//   update_btb, branch_outcome, branch_target, pc            BTB training
//   redirect, redirect_pc, flush                             fetch recovery
//   underflow_err                                            sticky protocol error
interface branch_update_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              fq_push;
    logic [WORD_W-1:0] fq_pc;
    logic              fq_pred_outcome;
    logic              fq_hit;
    logic [WORD_W-1:0] fq_pred_target;
    logic              fq_full;
    logic              fq_empty;
    logic              ex_valid;
    logic              ex_taken;
    logic [WORD_W-1:0] ex_target;
    logic              update_btb;
    logic              branch_outcome;
    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] pc;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              flush;
    logic              underflow_err;
`ifdef BRU_STATS_EN
    logic [31:0]       stat_resolved;
    logic [31:0]       stat_mispred;
`endif

    modport master (
        output fq_push, fq_pc, fq_pred_outcome, fq_hit, fq_pred_target,
        output ex_valid, ex_taken, ex_target,
        input  fq_full, fq_empty,
        input  update_btb, branch_outcome, branch_target, pc,
        input  redirect, redirect_pc, flush, underflow_err
`ifdef BRU_STATS_EN
        , input stat_resolved, stat_mispred
`endif
    );

    modport slave (
        input  fq_push, fq_pc, fq_pred_outcome, fq_hit, fq_pred_target,
        input  ex_valid, ex_taken, ex_target,
        output fq_full, fq_empty,
        output update_btb, branch_outcome, branch_target, pc,
        output redirect, redirect_pc, flush, underflow_err
`ifdef BRU_STATS_EN
        , output stat_resolved, stat_mispred
`endif
    );
endinterface

// File: rtl/branch_update_ctrl.sv
// branch_update_ctrl
// Update-side partner of the BTB lookup. Fetch pushes every prediction it
// made into an in-order queue; when execute resolves the oldest branch the
// head entry is compared against the real outcome, the BTB is trained and,
// on a mispredict, fetch is redirected and the pipeline flushed.
//
// Optional feature macro: BRU_STATS_EN
//   defined   - stat_resolved / stat_mispred saturating counters on the bus
//   undefined - no statistics hardware
//
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset
//   bus  branch_update_ctrl_if.slave (queue push, resolve, training, redirect)
//
// Parameters:
//   WORD_W        PC / target width
//   QDEPTH        prediction queue depth (power of two, >= 2)
//   FLUSH_CYCLES  cycles flush is held after a mispredict (>= 1)
module branch_update_ctrl #(
    parameter int WORD_W       = 32,
    parameter int QDEPTH       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 CLK,
    input logic                 RST,
    branch_update_ctrl_if.slave bus
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QDEPTH);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t            state, state_next;
    logic [FC_W-1:0]   fcnt, fcnt_next;

    logic [WORD_W-1:0] pc_mem     [QDEPTH];
    logic [WORD_W-1:0] target_mem [QDEPTH];
    logic [QDEPTH-1:0] outcome_mem;
    logic [QDEPTH-1:0] hit_mem;

    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic              running;
    logic              push_ok;
    logic              pop_ok;
    logic              enter_flush;
    logic              train;

    logic [WORD_W-1:0] pc_head;
    logic [WORD_W-1:0] pc_head_plus4;
    logic              hit_head;
    logic              outcome_head;
    logic [WORD_W-1:0] target_head;
    logic [WORD_W-1:0] pred_next;
    logic [WORD_W-1:0] act_next;
    logic              mispredict;

    assign bus.fq_full  = (count == CNT_MAX);
    assign bus.fq_empty = (count == '0);

    assign running = (state == RUN);
    assign push_ok = bus.fq_push  && !bus.fq_full  && running;
    assign pop_ok  = bus.ex_valid && !bus.fq_empty && running;

    assign pc_head       = pc_mem[head];
    assign target_head   = target_mem[head];
    assign hit_head      = hit_mem[head];
    assign outcome_head  = outcome_mem[head];
    assign pc_head_plus4 = pc_head + WORD_W'(4);

    // Compare next-fetch addresses rather than direction alone, so a taken
    // branch predicted to the wrong target also counts as a mispredict.
    assign pred_next  = (hit_head && outcome_head) ? target_head : pc_head_plus4;
    assign act_next   = bus.ex_taken ? bus.ex_target : pc_head_plus4;
    assign mispredict = (pred_next != act_next);

    // Not-taken branches that missed the BTB carry no information worth storing.
    assign train = pop_ok && (bus.ex_taken || hit_head);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        fcnt_next   = fcnt;
        enter_flush = 1'b0;
        bus.flush   = 1'b0;
        case (state)
            RUN: begin
                if (pop_ok && mispredict) begin
                    state_next  = FLUSH;
                    fcnt_next   = FC_LOAD;
                    enter_flush = 1'b1;
                end
            end
            FLUSH: begin
                bus.flush = 1'b1;
                if (fcnt == '0) begin
                    state_next = RUN;
                end else begin
                    fcnt_next = fcnt - 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Entering FLUSH discards every younger (wrong-path) prediction, including
    // one pushed in the same cycle as the mispredicting pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (enter_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head <= head + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            pc_mem[tail]      <= bus.fq_pc;
            target_mem[tail]  <= bus.fq_pred_target;
            outcome_mem[tail] <= bus.fq_pred_outcome;
            hit_mem[tail]     <= bus.fq_hit;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.update_btb     <= 1'b0;
            bus.branch_outcome <= 1'b0;
            bus.branch_target  <= '0;
            bus.pc             <= '0;
            bus.redirect       <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.underflow_err  <= 1'b0;
        end else begin
            bus.update_btb <= train;
            bus.redirect   <= pop_ok && mispredict;
            if (train) begin
                bus.branch_outcome <= bus.ex_taken;
                bus.branch_target  <= bus.ex_target;
                bus.pc             <= pc_head;
            end
            if (pop_ok && mispredict) begin
                bus.redirect_pc <= act_next;
            end
            if (bus.ex_valid && bus.fq_empty && running) begin
                bus.underflow_err <= 1'b1;
            end
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.stat_resolved <= '0;
            bus.stat_mispred  <= '0;
        end else begin
            if (pop_ok && (bus.stat_resolved != '1)) begin
                bus.stat_resolved <= bus.stat_resolved + 1'b1;
            end
            if (pop_ok && mispredict && (bus.stat_mispred != '1)) begin
                bus.stat_mispred <= bus.stat_mispred + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// tb_branch_update_ctrl
// Directed and randomized stimulus for branch_update_ctrl, checked against a
// queue-based reference model of the prediction/resolve/flush behaviour.
module tb_branch_update_ctrl;

    localparam int WORD_W       = 32;
    localparam int QDEPTH       = 8;
    localparam int FLUSH_CYCLES = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct {
        word_t pc;
        logic  pred_outcome;
        logic  hit;
        word_t pred_target;
    } rec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    branch_update_ctrl_if #(.WORD_W(WORD_W)) bus ();

    branch_update_ctrl #(
        .WORD_W      (WORD_W),
        .QDEPTH      (QDEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int check_count = 0;
    int fail_count  = 0;

    rec_t  model_q[$];
    int    flush_left;
    logic  exp_underflow;
    logic  exp_update;
    logic  exp_outcome;
    word_t exp_target;
    word_t exp_pc;
    logic  exp_redirect;
    word_t exp_redirect_pc;
    int    exp_resolved;
    int    exp_mispred;

    task automatic checkOutput(input string tag, input word_t actual, input word_t expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        flush_left      = 0;
        exp_underflow   = 1'b0;
        exp_update      = 1'b0;
        exp_outcome     = 1'b0;
        exp_target      = '0;
        exp_pc          = '0;
        exp_redirect    = 1'b0;
        exp_redirect_pc = '0;
        exp_resolved    = 0;
        exp_mispred     = 0;
    endtask

    task automatic driveIdle();
        bus.fq_push         = 1'b0;
        bus.fq_pc           = '0;
        bus.fq_pred_outcome = 1'b0;
        bus.fq_hit          = 1'b0;
        bus.fq_pred_target  = '0;
        bus.ex_valid        = 1'b0;
        bus.ex_taken        = 1'b0;
        bus.ex_target       = '0;
    endtask

    task automatic checkRegistered();
        checkOutput("update_btb", bus.update_btb, exp_update);
        checkOutput("redirect", bus.redirect, exp_redirect);
        checkOutput("flush", bus.flush, word_t'(flush_left > 0));
        checkOutput("underflow_err", bus.underflow_err, exp_underflow);
        checkOutput("branch_outcome", bus.branch_outcome, exp_outcome);
        checkOutput("branch_target", bus.branch_target, exp_target);
        checkOutput("pc", bus.pc, exp_pc);
        checkOutput("redirect_pc", bus.redirect_pc, exp_redirect_pc);
`ifdef BRU_STATS_EN
        checkOutput("stat_resolved", bus.stat_resolved, word_t'(exp_resolved));
        checkOutput("stat_mispred", bus.stat_mispred, word_t'(exp_mispred));
`endif
    endtask

    // Asynchronous reset: outputs are checked while RST is still high.
    task automatic applyReset();
        @(negedge CLK);
        RST = 1'b1;
        driveIdle();
        modelReset();
        #2;
        checkOutput("rst_fq_empty", bus.fq_empty, 1);
        checkOutput("rst_fq_full", bus.fq_full, 0);
        checkRegistered();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // One clock of stimulus, model update and checking.
    task automatic applyStimulus(input logic push, input word_t push_pc, input logic pred_outcome,
                                 input logic hit, input word_t pred_target,
                                 input logic ex_valid, input logic ex_taken, input word_t ex_target);
        logic  running;
        logic  do_pop;
        logic  do_push;
        logic  mis;
        rec_t  head_rec;
        rec_t  new_rec;
        word_t pred_next;
        word_t act_next;

        @(negedge CLK);
        bus.fq_push         = push;
        bus.fq_pc           = push_pc;
        bus.fq_pred_outcome = pred_outcome;
        bus.fq_hit          = hit;
        bus.fq_pred_target  = pred_target;
        bus.ex_valid        = ex_valid;
        bus.ex_taken        = ex_taken;
        bus.ex_target       = ex_target;
        #1;
        checkOutput("fq_full", bus.fq_full, word_t'(model_q.size() == QDEPTH));
        checkOutput("fq_empty", bus.fq_empty, word_t'(model_q.size() == 0));

        running = (flush_left == 0);
        do_pop  = running && ex_valid && (model_q.size() > 0);
        do_push = running && push && (model_q.size() < QDEPTH);
        mis     = 1'b0;
        if (running && ex_valid && model_q.size() == 0) begin
            exp_underflow = 1'b1;
        end
        exp_update   = 1'b0;
        exp_redirect = 1'b0;
        if (do_pop) begin
            head_rec  = model_q[0];
            pred_next = (head_rec.hit && head_rec.pred_outcome) ? head_rec.pred_target
                                                                : head_rec.pc + 32'd4;
            act_next  = ex_taken ? ex_target : head_rec.pc + 32'd4;
            mis       = (pred_next != act_next);
            if (ex_taken || head_rec.hit) begin
                exp_update  = 1'b1;
                exp_outcome = ex_taken;
                exp_target  = ex_target;
                exp_pc      = head_rec.pc;
            end
            if (mis) begin
                exp_redirect    = 1'b1;
                exp_redirect_pc = act_next;
                exp_mispred++;
            end
            exp_resolved++;
            void'(model_q.pop_front());
        end
        if (do_push) begin
            new_rec.pc           = push_pc;
            new_rec.pred_outcome = pred_outcome;
            new_rec.hit          = hit;
            new_rec.pred_target  = pred_target;
            model_q.push_back(new_rec);
        end
        if (mis) begin
            model_q.delete();
            flush_left = FLUSH_CYCLES;
        end else if (flush_left > 0) begin
            flush_left--;
        end

        @(posedge CLK);
        #1;
        checkRegistered();
    endtask

    task automatic pushRec(input word_t p, input logic po, input logic h, input word_t pt);
        applyStimulus(1'b1, p, po, h, pt, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic taken, input word_t tgt);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, taken, tgt);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        word_t r_pc;
        word_t r_pt;
        word_t r_tgt;
        logic  r_taken;
        logic  r_push;
        logic  r_exv;

        driveIdle();
        modelReset();
        applyReset();

        // Reset with three entries queued
        pushRec(32'h10, 1'b0, 1'b0, '0);
        pushRec(32'h20, 1'b0, 1'b0, '0);
        pushRec(32'h30, 1'b0, 1'b0, '0);
        applyReset();
        idle();

        // Correctly predicted taken branch
        pushRec(32'h100, 1'b1, 1'b1, 32'h200);
        resolve(1'b1, 32'h200);
        idle();

        // Taken branch that missed the BTB, pushes during the flush window
        pushRec(32'h140, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h80);
        applyStimulus(1'b1, 32'h504, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 32'h508, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h50c, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        resolve(1'b0, '0);
        idle();

        // Predicted taken, actually not taken
        pushRec(32'h300, 1'b1, 1'b1, 32'h400);
        resolve(1'b0, 32'h0);
        idle();
        idle();

        // Fill, overflow, push+pop while full, then pairs across the wrap
        for (int i = 0; i < QDEPTH + 1; i++) begin
            pushRec(32'h1000 + 32'(i * 16), 1'b1, 1'b1, 32'h2000 + 32'(i * 16));
        end
        applyStimulus(1'b1, 32'h9990, 1'b1, 1'b1, 32'h9999, 1'b1, 1'b1, model_q[0].pred_target);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 32'h3000 + 32'(i * 16), 1'b0, 1'b0, '0,
                          1'b1, model_q[0].hit && model_q[0].pred_outcome,
                          model_q[0].pred_target);
        end
        for (int i = 0; i < QDEPTH + 2 && model_q.size() > 0; i++) begin
            resolve(model_q[0].hit && model_q[0].pred_outcome, model_q[0].pred_target);
        end

        // Resolve with nothing queued
        resolve(1'b1, 32'h44);
        idle();
        resolve(1'b0, 32'h0);

        // Reset in the middle of a flush
        applyReset();
        pushRec(32'h700, 1'b0, 1'b0, '0);
        resolve(1'b1, 32'h900);
        applyReset();
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r_push = ($urandom_range(0, 3) != 0);
            r_exv  = ($urandom_range(0, 2) == 0);
            r_pc   = {$urandom_range(0, 1023), 2'b00};
            r_pt   = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200;
            if (model_q.size() > 0 && $urandom_range(0, 1) != 0) begin
                r_taken = model_q[0].hit && model_q[0].pred_outcome;
                r_tgt   = model_q[0].pred_target;
            end else begin
                r_taken = 1'($urandom_range(0, 1));
                r_tgt   = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h200;
            end
            applyStimulus(r_push, r_pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_pt,
                          r_exv, r_taken, r_tgt);
            if (n == 200) begin
                applyReset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
